// File: rtl/pll_ctrl_pkg.sv
// Shared types and widths for the PLL power-up / lock-supervision sequencer.
package pll_ctrl_pkg;

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned RETRY_W = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETTLE    = 3'd1,
    WAIT_LOCK = 3'd2,
    LOCKED    = 3'd3,
    OFF       = 3'd4,
    FAIL      = 3'd5
  } state_e;

endpackage

// File: rtl/pll_ctrl_lock_filter.sv
// Lock-loss filter: counts consecutive low pll_lock samples, pulses lost on the
// sample that reaches unlock_filter.
module pll_lock_filter
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned unlock_filter = 2
) (
  input  logic rclk,
  input  logic rst_n,
  input  logic clr,
  input  logic pll_lock,
  output logic lost
);

  localparam logic [CNT_W-1:0] LOW_LAST = CNT_W'(unlock_filter - 1);

  logic [CNT_W-1:0] low_cnt;

  // lost is combinational so the sequencer leaves LOCKED on the qualifying edge.
  assign lost = !clr && !pll_lock && (low_cnt == LOW_LAST);

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      low_cnt <= '0;
    end else if (clr || pll_lock || lost) begin
      low_cnt <= '0;
    end else begin
      low_cnt <= low_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pll_ctrl.sv
// PLL power-up and lock-supervision sequencer: drives pll_core en/fbdiv, waits
// for lock with timeout, cycles the PLL on timeout or lock loss with bounded retries.
module pll_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned settle_cycles       = 4,
  parameter int unsigned lock_timeout_cycles = 200,
  parameter int unsigned off_cycles          = 4,
  parameter int unsigned unlock_filter       = 2,
  parameter int unsigned max_retries         = 3
) (
  input  logic               rclk,
  input  logic               rst_n,
  input  logic               req,
  input  logic [7:0]         fbdiv_cfg,
  input  logic               pll_lock,
  output logic               pll_en,
  output logic [7:0]         pll_fbdiv,
  output logic               clk_ready,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [2:0]         state
);

  if (settle_cycles < 1 || settle_cycles > 65535) begin : g_bad_settle
    $error("pll_ctrl: settle_cycles must be in 1..65535");
  end
  if (lock_timeout_cycles < 1 || lock_timeout_cycles > 65535) begin : g_bad_timeout
    $error("pll_ctrl: lock_timeout_cycles must be in 1..65535");
  end
  if (off_cycles < 1 || off_cycles > 65535) begin : g_bad_off
    $error("pll_ctrl: off_cycles must be in 1..65535");
  end
  if (unlock_filter < 1 || unlock_filter > 65535) begin : g_bad_filter
    $error("pll_ctrl: unlock_filter must be in 1..65535");
  end
  if (max_retries > 15) begin : g_bad_retries
    $error("pll_ctrl: max_retries must be <= 15");
  end

  // SETTLE exits on count == settle_cycles: the capture edge plus settle_cycles
  // stable cycles, so pll_en rises after edge E(settle_cycles+1).
  localparam logic [CNT_W-1:0]   SETTLE_LAST  = CNT_W'(settle_cycles);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(lock_timeout_cycles - 1);
  localparam logic [CNT_W-1:0]   OFF_LAST     = CNT_W'(off_cycles - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(max_retries);

  state_e             cur, nxt;
  logic [CNT_W-1:0]   cnt;
  logic [RETRY_W-1:0] retry_nxt;
  logic               capture;
  logic               retry_evt;
  logic               lost;

  pll_lock_filter #(
    .unlock_filter(unlock_filter)
  ) u_filter (
    .rclk    (rclk),
    .rst_n   (rst_n),
    .clr     (cur != LOCKED),
    .pll_lock(pll_lock),
    .lost    (lost)
  );

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      cur       <= IDLE;
      cnt       <= '0;
      retry_cnt <= '0;
      pll_fbdiv <= '0;
    end else begin
      cur       <= nxt;
      retry_cnt <= retry_nxt;
      if (nxt != cur) begin
        cnt <= '0;
      end else if (cnt != '1) begin
        cnt <= cnt + 1'b1;
      end
      if (capture) begin
        pll_fbdiv <= (fbdiv_cfg == '0) ? 8'd1 : fbdiv_cfg;
      end
    end
  end

  always_comb begin
    nxt       = cur;
    retry_nxt = retry_cnt;
    capture   = 1'b0;
    retry_evt = 1'b0;
    if (!req) begin
      nxt       = IDLE;
      retry_nxt = '0;
    end else begin
      unique case (cur)
        IDLE: begin
          nxt       = SETTLE;
          capture   = 1'b1;
          retry_nxt = '0;
        end
        SETTLE: begin
          if (cnt == SETTLE_LAST) nxt = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (pll_lock) nxt = LOCKED;
          else if (cnt == TIMEOUT_LAST) retry_evt = 1'b1;
        end
        LOCKED: begin
          if (lost) retry_evt = 1'b1;
        end
        OFF: begin
          if (cnt == OFF_LAST) nxt = SETTLE;
        end
        FAIL: begin
          nxt = FAIL;
        end
        default: begin
          nxt = IDLE;
        end
      endcase
      if (retry_evt) begin
        if (retry_cnt < RETRY_MAX) begin
          retry_nxt = retry_cnt + 1'b1;
          nxt       = OFF;
        end else begin
          nxt = FAIL;
        end
      end
    end
  end

  assign pll_en    = (cur == WAIT_LOCK) || (cur == LOCKED);
  assign clk_ready = (cur == LOCKED);
  assign fail      = (cur == FAIL);
  assign state     = cur;

endmodule
